// File: rtl/router_out_port.sv
// Per-port transmit stage: output register plus circular FIFO, val/ret link handshake.
// Optional stall counter is enabled by defining ROUTER_OUT_STALL_CNT_EN.
module router_out_port #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_W     = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] Data_in,
   input  logic                  wr_en,
   output logic                  full,
   output logic [DATA_WIDTH-1:0] Data_out,
   output logic                  val,
   input  logic                  ret
`ifdef ROUTER_OUT_STALL_CNT_EN
   ,
   output logic [15:0]           stall_cnt
`endif
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

   state_t state, state_nxt;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_W-1:0]     wr_ptr, rd_ptr;
   logic [ADDR_W:0]       count, count_nxt;

   logic xfer, out_free, fifo_empty, wr_acc;
   logic load_fifo, load_in, load, push, pop;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_comb begin
      xfer       = val && !ret;
      out_free   = !val || xfer;
      fifo_empty = (count == '0);
      // full is registered, so a same-cycle pop never frees space for a write
      wr_acc     = wr_en && !full;
      load_fifo  = out_free && !fifo_empty;
      load_in    = out_free && fifo_empty && wr_acc;
      load       = load_fifo || load_in;
      push       = wr_acc && !load_in;
      pop        = load_fifo;
   end

   always_comb begin
      count_nxt = count;
      if (push && !pop)
         count_nxt = count + CNT_ONE;
      else if (pop && !push)
         count_nxt = count - CNT_ONE;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:       if (load) state_nxt = SEND;
         SEND, HOLD: begin
            if (ret)
               state_nxt = HOLD;
            else if (load)
               state_nxt = SEND;
            else
               state_nxt = IDLE;
         end
         default:    state_nxt = IDLE;
      endcase
   end

   assign val = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         full   <= 1'b0;
      end else begin
         state  <= state_nxt;
         count  <= count_nxt;
         full   <= (count_nxt == CNT_FULL);
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= Data_in;
   end

   // Output register: reset to zero; holds its last value when nothing loads
   always_ff @(posedge clk) begin
      if (rst)
         Data_out <= '0;
      else if (load_fifo)
         Data_out <= mem[rd_ptr];
      else if (load_in)
         Data_out <= Data_in;
   end

`ifdef ROUTER_OUT_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (val && ret)
         stall_cnt <= sat_inc16(stall_cnt);
   end
`endif

endmodule

// File: tb/tb_router_out_port.sv
// Directed bench for router_out_port: reset, fall-through, streaming, back-pressure, reset flush.
module tb_router_out_port;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] Data_in;
   logic       wr_en;
   logic       full;
   logic [7:0] Data_out;
   logic       val;
   logic       ret;
`ifdef ROUTER_OUT_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   router_out_port #(.DATA_WIDTH(8), .ADDR_W(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .Data_in  (Data_in),
      .wr_en    (wr_en),
      .full     (full),
      .Data_out (Data_out),
      .val      (val),
      .ret      (ret)
`ifdef ROUTER_OUT_STALL_CNT_EN
      ,
      .stall_cnt(stall_cnt)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_en = 1'b0; Data_in = 8'h00; ret = 1'b0;
      tick(); tick();
      rst = 1'b0;
      n_tests++;
      if (val !== 1'b0 || full !== 1'b0 || Data_out !== 8'h00) begin
         n_fail++;
         $display("FAIL reset: val=%b full=%b Data_out=%h required 0 0 00", val, full, Data_out);
      end
   endtask

   task automatic test_single();
      Data_in = 8'hA5; wr_en = 1'b1; ret = 1'b0;
      tick();
      wr_en = 1'b0;
      n_tests++;
      if (val !== 1'b1 || Data_out !== 8'hA5 || full !== 1'b0) begin
         n_fail++;
         $display("FAIL single_load: val=%b Data_out=%h full=%b required 1 a5 0", val, Data_out, full);
      end
      tick();
      n_tests++;
      if (val !== 1'b0 || Data_out !== 8'hA5 || full !== 1'b0) begin
         n_fail++;
         $display("FAIL single_drain: val=%b Data_out=%h full=%b required 0 a5 0", val, Data_out, full);
      end
   endtask

   task automatic test_stream();
      ret = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         Data_in = 8'(i); wr_en = 1'b1;
         tick();
         n_tests++;
         if (val !== 1'b1 || Data_out !== 8'(i) || full !== 1'b0) begin
            n_fail++;
            $display("FAIL stream[%0d]: val=%b Data_out=%h full=%b required 1 %h 0", i, val, Data_out, full, 8'(i));
         end
      end
      wr_en = 1'b0;
      tick();
      n_tests++;
      if (val !== 1'b0) begin
         n_fail++;
         $display("FAIL stream_end: val=%b required 0", val);
      end
   endtask

   task automatic test_backpressure();
      ret = 1'b1;
      for (int i = 0; i < 5; i++) begin
         Data_in = 8'(8'h10 + i); wr_en = 1'b1;
         tick();
         n_tests++;
         if (val !== 1'b1 || Data_out !== 8'h10 || full !== (i == 4)) begin
            n_fail++;
            $display("FAIL bp_fill[%0d]: val=%b Data_out=%h full=%b required 1 10 %b", i, val, Data_out, full, (i == 4));
         end
      end
      Data_in = 8'hFF; wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
      n_tests++;
      if (full !== 1'b1 || Data_out !== 8'h10 || val !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_overfill: full=%b Data_out=%h val=%b required 1 10 1", full, Data_out, val);
      end
      ret = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         n_tests++;
         if (val !== 1'b1 || Data_out !== 8'(8'h10 + k) || full !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain[%0d]: val=%b Data_out=%h full=%b required 1 %h 0", k, val, Data_out, full, 8'(8'h10 + k));
         end
      end
      tick();
      n_tests++;
      if (val !== 1'b0 || Data_out !== 8'h14) begin
         n_fail++;
         $display("FAIL bp_no_stale: val=%b Data_out=%h required 0 14", val, Data_out);
      end
   endtask

   task automatic test_ret_toggle();
      int sent = 0;
      int rcv  = 0;
      logic       xfer, stall;
      logic [7:0] d_before;
      for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
         ret = (cyc % 2 == 0);
         if (sent < 8 && full == 1'b0) begin
            Data_in = 8'(8'h20 + sent); wr_en = 1'b1; sent++;
         end else begin
            wr_en = 1'b0;
         end
         xfer = val && !ret;
         stall = val && ret;
         d_before = Data_out;
         tick();
         if (xfer) begin
            n_tests++;
            if (d_before !== 8'(8'h20 + rcv)) begin
               n_fail++;
               $display("FAIL toggle_order[%0d]: got %h required %h", rcv, d_before, 8'(8'h20 + rcv));
            end
            rcv++;
         end
         if (stall) begin
            n_tests++;
            if (Data_out !== d_before || val !== 1'b1) begin
               n_fail++;
               $display("FAIL toggle_hold: Data_out=%h val=%b required %h 1", Data_out, val, d_before);
            end
         end
      end
      wr_en = 1'b0; ret = 1'b0;
      n_tests++;
      if (rcv != 8) begin
         n_fail++;
         $display("FAIL toggle_count: received %0d required 8", rcv);
      end
      tick();
      n_tests++;
      if (val !== 1'b0) begin
         n_fail++;
         $display("FAIL toggle_end: val=%b required 0", val);
      end
   endtask

   task automatic test_reset_mid();
      ret = 1'b1;
      for (int i = 0; i < 3; i++) begin
         Data_in = 8'(8'h30 + i); wr_en = 1'b1;
         tick();
      end
      wr_en = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      n_tests++;
      if (val !== 1'b0 || full !== 1'b0 || Data_out !== 8'h00) begin
         n_fail++;
         $display("FAIL mid_reset: val=%b full=%b Data_out=%h required 0 0 00", val, full, Data_out);
      end
      ret = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_tests++;
         if (val !== 1'b0 || Data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset_stale[%0d]: val=%b Data_out=%h required 0 00", k, val, Data_out);
         end
      end
   endtask

`ifdef ROUTER_OUT_STALL_CNT_EN
   task automatic test_stall_cnt();
      rst = 1'b1; tick(); rst = 1'b0;
      ret = 1'b1; Data_in = 8'h55; wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      n_tests++;
      if (stall_cnt !== 16'd10) begin
         n_fail++;
         $display("FAIL stall_cnt: got %0d required 10", stall_cnt);
      end
      rst = 1'b1; tick(); rst = 1'b0; ret = 1'b0;
      n_tests++;
      if (stall_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL stall_cnt_reset: got %0d required 0", stall_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_ret_toggle();
      test_reset_mid();
`ifdef ROUTER_OUT_STALL_CNT_EN
      test_stall_cnt();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
